// File: rtl/qsa_pkg.sv
// Shared definitions for the quad serial adder controller slice.
// Contents: the sequencer state enum (2-bit encoding) and the default
// operand width and digit width that the top module uses as parameter defaults.
package qsa_pkg;

  localparam int unsigned QSA_WIDTH = 64;
  localparam int unsigned QSA_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } qsa_state_e;

endpackage

// File: rtl/qsa_step_counter.sv
// Step counter for the serial adder sequencer.
// The counter is exactly CNT_W bits wide. It wraps to 0 after the terminal
// value STEPS-1.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   i_clr    : synchronous clear to 0 (takes priority over i_inc)
//   i_inc    : advance by one; wraps to 0 after the terminal value
//   o_tc     : high while the count equals STEPS-1
module qsa_step_counter #(
  parameter int unsigned STEPS = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc)
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/quad_serial_adder_ctrl.sv
// Moore sequencer for the 4-bit-per-step serial adder datapath. The
// datapath consists of shift registers A, B and R and a carry DFF.
// Sequence: IDLE -> LOAD -> SHIFT (STEPS cycles) -> DONE -> IDLE.
// All outputs decode from the state only.
// Optional macro QSA_ABORT_EN adds the abort input. An abort in LOAD or SHIFT
// returns the sequencer to IDLE without a done pulse.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   start               : request; sampled only in IDLE
//   busy                : high in LOAD and SHIFT
//   done                : one-cycle pulse; datapath result/carry valid then
//   enbA/enbB/enbR      : shift enables for A, B and R
//   loadA/loadB/loadR   : parallel loads (loadR is tied 0)
//   zeroA/zeroB         : clears for A and B (tied 0)
//   zeroR/zeroD         : clear R, clear carry DFF
//   abort               : cancel request (only with QSA_ABORT_EN)
import qsa_pkg::*;

module quad_serial_adder_ctrl #(
  parameter int unsigned WIDTH = QSA_WIDTH,
  parameter int unsigned DIGIT = QSA_DIGIT,
  parameter int unsigned STEPS = WIDTH / DIGIT,
  parameter int unsigned CNT_W = $clog2(STEPS)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef QSA_ABORT_EN
  input  logic abort,
`endif
  output logic busy,
  output logic done,
  output logic enbA,
  output logic enbB,
  output logic enbR,
  output logic loadA,
  output logic loadB,
  output logic loadR,
  output logic zeroA,
  output logic zeroB,
  output logic zeroR,
  output logic zeroD
);

  qsa_state_e r_state;
  qsa_state_e w_next;
  logic       w_tc;
  logic       w_abort;

`ifdef QSA_ABORT_EN
  // Only meaningful while an operation is in flight.
  assign w_abort = abort && ((r_state == LOAD) || (r_state == SHIFT));
`else
  assign w_abort = 1'b0;
`endif

  // The counter runs only in SHIFT. It is held at 0 in every other state, so
  // it starts each operation at step 0. An abort also clears it in the same
  // edge.
  qsa_step_counter #(
    .STEPS (STEPS),
    .CNT_W (CNT_W)
  ) u_step (
    .clk   (clk),
    .rst   (rst),
    .i_clr ((r_state != SHIFT) || w_abort),
    .i_inc (r_state == SHIFT),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = start ? LOAD : IDLE;
      LOAD:  w_next = w_abort ? IDLE : SHIFT;
      SHIFT: begin
        if (w_abort)
          w_next = IDLE;
        else if (w_tc)
          w_next = DONE;
      end
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    enbA  = 1'b0;
    enbB  = 1'b0;
    enbR  = 1'b0;
    loadA = 1'b0;
    loadB = 1'b0;
    loadR = 1'b0;
    zeroA = 1'b0;
    zeroB = 1'b0;
    zeroR = 1'b0;
    zeroD = 1'b0;
    unique case (r_state)
      IDLE:  zeroD = 1'b1;
      LOAD: begin
        busy  = 1'b1;
        loadA = 1'b1;
        loadB = 1'b1;
        zeroR = 1'b1;
        zeroD = 1'b1;
      end
      SHIFT: begin
        busy = 1'b1;
        enbA = 1'b1;
        enbB = 1'b1;
        enbR = 1'b1;
      end
      DONE:  done = 1'b1;
      default: zeroD = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_quad_serial_adder_ctrl.sv
// Closed-loop bench: the controller drives a behavioural 4-bit serial adder
// datapath. The bench pushes expected sums when an operation starts and
// pops them when done is seen.
module tb_quad_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic busy, done, enbA, enbB, enbR, loadA, loadB, loadR;
  logic zeroA, zeroB, zeroR, zeroD;

  logic [63:0] op_a, op_b;
  logic [63:0] r_a, r_b, r_r;
  logic        r_c;
  logic [4:0]  w_sum;
  logic [11:0] w_outs;

  int checks = 0;
  int errors = 0;
  longint r_cyc = 0;
  logic [64:0] exp_q[$];
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  quad_serial_adder_ctrl #(
    .WIDTH (64),
    .DIGIT (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef QSA_ABORT_EN
    .abort (abort),
`endif
    .busy  (busy),
    .done  (done),
    .enbA  (enbA),
    .enbB  (enbB),
    .enbR  (enbR),
    .loadA (loadA),
    .loadB (loadB),
    .loadR (loadR),
    .zeroA (zeroA),
    .zeroB (zeroB),
    .zeroR (zeroR),
    .zeroD (zeroD)
  );

  assign w_outs = {busy, done, enbA, enbB, enbR, loadA, loadB, loadR,
                   zeroA, zeroB, zeroR, zeroD};

  // Behavioural datapath: digits are consumed LSB first, and the result
  // shifts in from the top.
  assign w_sum = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'd0, r_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_r <= '0;
      r_c <= 1'b0;
    end else begin
      if (zeroA)      r_a <= '0;
      else if (loadA) r_a <= op_a;
      else if (enbA)  r_a <= {4'd0, r_a[63:4]};
      if (zeroB)      r_b <= '0;
      else if (loadB) r_b <= op_b;
      else if (enbB)  r_b <= {4'd0, r_b[63:4]};
      if (zeroR)      r_r <= '0;
      else if (enbR)  r_r <= {w_sum[3:0], r_r[63:4]};
      if (zeroD)      r_c <= 1'b0;
      else if (enbR)  r_c <= w_sum[4];
    end
  end

  always @(posedge clk) r_cyc <= r_cyc + 1;

  task automatic chk(input string tag, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Invariants and scoreboard pops.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      chk("ld_enb_overlap", 65'((loadA | loadB) & (enbA | enbB | enbR)), 65'd0);
      chk("zeroR_enbR", 65'(zeroR & enbR), 65'd0);
      chk("tied_low", 65'({loadR, zeroA, zeroB}), 65'd0);
      chk("busy_decode", 65'(busy), 65'(loadA | enbA));
      if (prev_done) chk("done_width", 65'(done), 65'd0);
      prev_done = done;
      if (done) begin
        if (exp_q.size() == 0) chk("spurious_done", 65'd1, 65'd0);
        else chk("result", {r_c, r_r}, exp_q.pop_front());
      end
    end
  end

  // Call this just after a posedge while the controller is in IDLE.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b);
    int  n;
    bit  seen;
    op_a = a;
    op_b = b;
    start = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    if (seen) chk("latency", 65'(n), 65'd18);
    else      chk("done_timeout", 65'd0, 65'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output longint t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        t = r_cyc;
        break;
      end
    end
  endtask

  initial begin
    longint t0, t1, t2;
    bit ok0, ok1, ok2;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 65'(w_outs), 65'h001);
    @(posedge clk);
    #1;

    // Reset in the middle of an operation.
    op_a = 64'h5;
    op_b = 64'h7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_async_outputs", 65'(w_outs), 65'h001);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_release_outputs", 65'(w_outs), 65'h001);
    @(posedge clk);
    #1;

    run_op(64'h1, 64'h1);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001);
    run_op(64'h0, 64'h0);

    // With start held high, three operations run back to back.
    op_a = 64'h0123_4567_89AB_CDEF;
    op_b = 64'h1111_1111_1111_1111;
    for (int k = 0; k < 3; k++) exp_q.push_back(65'h0_1234_5678_9ABC_DF00);
    start = 1'b1;
    wait_done(t0, ok0);
    wait_done(t1, ok1);
    wait_done(t2, ok2);
    start = 1'b0;
    chk("held_done_seen", 65'({ok0, ok1, ok2}), 65'h7);
    chk("period_1", 65'(t1 - t0), 65'd19);
    chk("period_2", 65'(t2 - t1), 65'd19);
    @(posedge clk);
    #1;

    // Reset at SHIFT step 7, which is 8 edges after the start edge.
    op_a = 64'hDEAD_BEEF_0000_1234;
    op_b = 64'h1111_2222_3333_4444;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1 chk("rst_shift_outputs", 65'(w_outs), 65'h001);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_shift_idle", 65'(w_outs), 65'h001);
    @(posedge clk);
    #1;
    run_op(64'hDEAD_BEEF_0000_1234, 64'h1111_2222_3333_4444);

`ifdef QSA_ABORT_EN
    // Abort at SHIFT step 5, which is 6 edges after the start edge.
    op_a = 64'h1234;
    op_b = 64'h4321;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", 65'(busy), 65'd0);
    chk("abort_outputs", 65'(w_outs), 65'h001);
    run_op(64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAB);
`endif

    repeat (3) @(posedge clk);
    chk("queue_empty", 65'(exp_q.size()), 65'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
